// File: rtl/fir_out_decim_pkg.sv
// Shared definitions for the FIR output stage: data width and the
// round-half-up / arithmetic-shift / clip rule used by stage 1.
package fir_pkg;

  localparam int FIR_DATA_W = 16;

  // Rounded, shifted and clipped value; 32-bit arithmetic leaves ample headroom.
  function automatic logic signed [31:0] sat_round(input logic signed [31:0] value,
                                                   input int shift, input int out_w);
    logic signed [31:0] r;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    r  = (value + (32'sd1 <<< (shift - 1))) >>> shift;
    hi = (32'sd1 <<< (out_w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (out_w - 1));
    if (r > hi) r = hi;
    else if (r < lo) r = lo;
    return r;
  endfunction

  // True when the rounded/shifted value falls outside the signed out_w range.
  function automatic logic sat_hit(input logic signed [31:0] value,
                                   input int shift, input int out_w);
    logic signed [31:0] r;
    r = (value + (32'sd1 <<< (shift - 1))) >>> shift;
    return (r > ((32'sd1 <<< (out_w - 1)) - 32'sd1)) || (r < -(32'sd1 <<< (out_w - 1)));
  endfunction

endpackage

// File: rtl/fir_out_decim_if.sv
// Sample streams of the FIR output stage: FIR-side input and consumer-side output.
// Handshake: in_valid has no back-pressure; an output transfer happens on every
// rising edge where out_valid && out_ready, and out_data is stable while stalled.
interface fir_out_decim_if
  import fir_pkg::*;
#(
  parameter int OUT_W = 8
);
  logic                         in_valid;
  logic signed [FIR_DATA_W-1:0] in_data;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [OUT_W-1:0]      out_data;

  modport master (output in_valid, in_data, out_ready, input out_valid, out_data);
  modport slave  (input in_valid, in_data, out_ready, output out_valid, out_data);
endinterface

// File: rtl/fir_out_decim_fifo.sv
// Synchronous FIFO with extra-MSB pointers and a combinational head read.
module fir_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic         do_pop;
  logic         do_push;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wptr[AW-1:0]] <= wdata;
        wptr              <= wptr + PTR_ONE;
      end
      if (do_pop) rptr <= rptr + PTR_ONE;
    end
  end
endmodule

// File: rtl/fir_out_decim.sv
// FIR output stage: decimate, round/shift/saturate, buffer, stream out.
// Define FIR_OUT_DECIM_AVG_EN to feed stage 1 with the sum of each DECIM group.
module fir_out_decim
  import fir_pkg::*;
#(
  parameter int DECIM = 3,
  parameter int SHIFT = 6,
  parameter int OUT_W = 8,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  fir_out_decim_if.slave      bus,
  output logic                sat_pulse,
  output logic                overflow,
  output logic [3:0]          phase
);
  localparam logic [3:0] LAST_PHASE = 4'(DECIM - 1);

  logic                     sel;
  logic signed [31:0]       sel_val;
  logic                     s1_valid;
  logic [OUT_W-1:0]         s1_data;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [OUT_W-1:0]         head;

  always_ff @(posedge clk) begin
    if (rst) phase <= '0;
    else if (bus.in_valid) phase <= (phase == LAST_PHASE) ? 4'd0 : phase + 4'd1;
  end

`ifdef FIR_OUT_DECIM_AVG_EN
  localparam int ACC_W = FIR_DATA_W + $clog2(DECIM);
  logic signed [ACC_W-1:0] acc;

  // The closing sample of a group is added combinationally so no input is lost.
  always_comb begin
    sel     = bus.in_valid && (phase == LAST_PHASE);
    sel_val = 32'(acc) + 32'(bus.in_data);
  end

  always_ff @(posedge clk) begin
    if (rst) acc <= '0;
    else if (bus.in_valid) acc <= (phase == LAST_PHASE) ? '0 : ACC_W'(sel_val);
  end
`else
  always_comb begin
    sel     = bus.in_valid && (phase == 4'd0);
    sel_val = 32'(bus.in_data);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      sat_pulse <= 1'b0;
    end else begin
      s1_valid  <= sel;
      sat_pulse <= sel && sat_hit(sel_val, SHIFT, OUT_W);
      if (sel) s1_data <= OUT_W'(sat_round(sel_val, SHIFT, OUT_W));
    end
  end

  fir_sync_fifo #(
    .W     (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s1_valid),
    .pop   (bus.out_ready),
    .wdata (s1_data),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = head;

  always_ff @(posedge clk) begin
    if (rst) overflow <= 1'b0;
    else if (s1_valid && fifo_full && !(bus.out_ready && !fifo_empty)) overflow <= 1'b1;
  end
endmodule

// File: tb/tb_fir_out_decim.sv
// Bench for fir_out_decim: a DECIM=1 and a DECIM=3 instance share one stimulus
// stream and are checked every cycle against a queue-based reference model.
module tb_fir_out_decim;
  import fir_pkg::*;

  localparam int SHIFT = 6;
  localparam int OUT_W = 8;
  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fir_out_decim_if #(.OUT_W(OUT_W)) bus1 ();
  fir_out_decim_if #(.OUT_W(OUT_W)) bus3 ();
  logic       sat1, ovf1, sat3, ovf3;
  logic [3:0] ph1, ph3;

  fir_out_decim #(.DECIM(1), .SHIFT(SHIFT), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .sat_pulse(sat1), .overflow(ovf1), .phase(ph1));
  fir_out_decim #(.DECIM(3), .SHIFT(SHIFT), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3), .sat_pulse(sat3), .overflow(ovf3), .phase(ph3));

  // ---------------- scoreboard state ----------------
  int         checks   = 0;
  int         failures = 0;
  int         dec[2]   = '{1, 3};
  int         cnt[2];
  int         acc[2];
  bit         pv[2];
  int         pd[2];
  bit         ps[2];
  bit         movf[2];
  bit         after_rst;
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  logic [7:0] got0[$];
  logic [7:0] got1[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int qsize(input int k);
    return (k == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic logic [7:0] qhead(input int k);
    return (k == 0) ? exp_q0[0] : exp_q1[0];
  endfunction

  task automatic qpush(input int k, input logic [7:0] v);
    if (k == 0) exp_q0.push_back(v); else exp_q1.push_back(v);
  endtask

  task automatic qpop(input int k);
    if (k == 0) void'(exp_q0.pop_front()); else void'(exp_q1.pop_front());
  endtask

  // floor((s + 2^(SHIFT-1)) / 2^SHIFT), then clip to the signed OUT_W range
  function automatic int ref_round(input int s, output bit sat);
    int div, q, r, hi, lo;
    div = 1 << SHIFT;
    q   = s + div / 2;
    r   = (q >= 0) ? q / div : -((-q + div - 1) / div);
    hi  = (1 << (OUT_W - 1)) - 1;
    lo  = -(1 << (OUT_W - 1));
    sat = 1'b0;
    if (r > hi) begin r = hi; sat = 1'b1; end
    else if (r < lo) begin r = lo; sat = 1'b1; end
    return r;
  endfunction

  // One rising edge of the reference: pop, push last selected result, select new one.
  task automatic model_edge(input int k, input bit v, input int d, input bit r);
    bit sat;
    if (rst) begin
      cnt[k] = 0; acc[k] = 0; pv[k] = 0; ps[k] = 0; movf[k] = 0;
      if (k == 0) exp_q0.delete(); else exp_q1.delete();
      return;
    end
    if (r && qsize(k) > 0) qpop(k);
    if (pv[k]) begin
      if (qsize(k) < DEPTH) qpush(k, 8'(pd[k]));
      else movf[k] = 1'b1;
    end
    pv[k] = 1'b0;
    ps[k] = 1'b0;
    sat   = 1'b0;
    if (v) begin
`ifdef FIR_OUT_DECIM_AVG_EN
      acc[k] += d;
      if (cnt[k] == dec[k] - 1) begin
        pv[k]  = 1'b1;
        pd[k]  = ref_round(acc[k], sat);
        acc[k] = 0;
      end
`else
      if (cnt[k] == 0) begin
        pv[k] = 1'b1;
        pd[k] = ref_round(d, sat);
      end
`endif
      cnt[k] = (cnt[k] + 1) % dec[k];
    end
    ps[k] = sat;
  endtask

  task automatic check_dut(input int k);
    logic       ov, sp, of;
    logic [7:0] od;
    logic [3:0] ph;
    if (k == 0) begin ov = bus1.out_valid; od = bus1.out_data; sp = sat1; of = ovf1; ph = ph1; end
    else        begin ov = bus3.out_valid; od = bus3.out_data; sp = sat3; of = ovf3; ph = ph3; end
    check($sformatf("d%0d_out_valid", dec[k]), {31'b0, ov}, {31'b0, qsize(k) > 0});
    if (qsize(k) > 0) check($sformatf("d%0d_out_data", dec[k]), {24'b0, od}, {24'b0, qhead(k)});
    else if (after_rst) check($sformatf("d%0d_rst_out_data", dec[k]), {24'b0, od}, 32'd0);
    check($sformatf("d%0d_sat_pulse", dec[k]), {31'b0, sp}, {31'b0, ps[k]});
    check($sformatf("d%0d_overflow", dec[k]), {31'b0, of}, {31'b0, movf[k]});
    check($sformatf("d%0d_phase", dec[k]), {28'b0, ph}, 32'(cnt[k]));
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input bit v, input int d, input bit r);
    bus1.in_valid = v; bus1.in_data = 16'(d); bus1.out_ready = r;
    bus3.in_valid = v; bus3.in_data = 16'(d); bus3.out_ready = r;
    if (!rst && r && bus1.out_valid) got0.push_back(bus1.out_data);
    if (!rst && r && bus3.out_valid) got1.push_back(bus3.out_data);
    @(posedge clk);
    model_edge(0, v, d, r);
    model_edge(1, v, d, r);
    after_rst = rst;
    #1;
    check_dut(0);
    check_dut(1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle(1'b0, 0, 1'b0);
    rst = 1'b0;
    got0.delete();
    got1.delete();
  endtask

  task automatic one_shot(input int d, input int expv, input bit es);
    cycle(1'b1, d, 1'b0);
    check($sformatf("shot_sat_%0d", d), {31'b0, sat1}, {31'b0, es});
    cycle(1'b0, 0, 1'b0);
    check($sformatf("shot_valid_%0d", d), {31'b0, bus1.out_valid}, 32'd1);
    check($sformatf("shot_data_%0d", d), {24'b0, bus1.out_data}, {24'b0, 8'(expv)});
    check($sformatf("shot_sat_clear_%0d", d), {31'b0, sat1}, 32'd0);
    cycle(1'b0, 0, 1'b1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [7:0] exp3[3];
`ifdef FIR_OUT_DECIM_AVG_EN
    exp3 = '{8'd6, 8'd15, 8'd24};
`else
    exp3 = '{8'd1, 8'd4, 8'd7};
`endif
    bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.out_ready = 1'b0;
    bus3.in_valid = 1'b0; bus3.in_data = '0; bus3.out_ready = 1'b0;

    do_reset();
    do_reset();
    check("rst_out_valid", {31'b0, bus1.out_valid}, 32'd0);
    check("rst_out_data", {24'b0, bus1.out_data}, 32'd0);
    check("rst_overflow", {31'b0, ovf3}, 32'd0);

    // latency: result visible two edges after the input
    cycle(1'b1, 320, 1'b1);
    check("lat_e0_valid", {31'b0, bus1.out_valid}, 32'd0);
    cycle(1'b0, 0, 1'b1);
    check("lat_e1_valid", {31'b0, bus1.out_valid}, 32'd1);
    check("lat_data", {24'b0, bus1.out_data}, 32'd5);
    cycle(1'b0, 0, 1'b1);

    // rounding and saturation edges
    one_shot(32, 1, 1'b0);
    one_shot(31, 0, 1'b0);
    one_shot(-32, 0, 1'b0);
    one_shot(-33, -1, 1'b0);
    one_shot(16000, 127, 1'b1);
    one_shot(-16000, -128, 1'b1);

    // DECIM=3 selection on nine back-to-back inputs
    do_reset();
    for (int i = 1; i <= 9; i++) cycle(1'b1, 64 * i, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 0, 1'b1);
    check("decim3_count", got1.size(), 32'd3);
    for (int i = 0; i < 3; i++)
      if (got1.size() > i) check($sformatf("decim3_out%0d", i), {24'b0, got1[i]}, {24'b0, exp3[i]});

    // backpressure: fifth sample dropped, first four retained in order
    do_reset();
    for (int i = 1; i <= 5; i++) cycle(1'b1, 64 * i, 1'b0);
    cycle(1'b0, 0, 1'b0);
    cycle(1'b0, 0, 1'b0);
    check("bp_overflow", {31'b0, ovf1}, 32'd1);
    got0.delete();
    for (int i = 0; i < 6; i++) cycle(1'b0, 0, 1'b1);
    check("bp_count", got0.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      if (got0.size() > i) check($sformatf("bp_out%0d", i), {24'b0, got0[i]}, 32'(i + 1));
    check("bp_drained", {31'b0, bus1.out_valid}, 32'd0);

    // reset mid-stream discards buffered samples and clears the sticky flag
    for (int i = 1; i <= 3; i++) cycle(1'b1, 64 * i, 1'b0);
    cycle(1'b0, 0, 1'b0);
    do_reset();
    check("mid_rst_valid", {31'b0, bus1.out_valid}, 32'd0);
    check("mid_rst_overflow", {31'b0, ovf1}, 32'd0);
    check("mid_rst_phase3", {28'b0, ph3}, 32'd0);
    cycle(1'b1, 640, 1'b1);
    cycle(1'b0, 0, 1'b1);
    check("mid_rst_next_data", {24'b0, bus1.out_data}, 32'd10);
    cycle(1'b0, 0, 1'b1);

    // randomized traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      bit v, r;
      int d;
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      d = int'($signed(16'($urandom)));
      if ($urandom_range(0, 7) == 0) d = d / 64;
      if ($urandom_range(0, 149) == 0) do_reset();
      else cycle(v, d, r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fir_out_decim.md
Name: fir_out_decim

Overview:
- Output stage placed directly downstream of the 3-tap FIR. Consumes the signed 16-bit filter result every valid cycle.
- Decimates by DECIM, rounds and shifts away the coefficient scaling, and saturates to OUT_W bits.
- Buffers results in a small FIFO and presents them over a valid/ready handshake to the next consumer (DAC/serializer/bus).

Parameters:
- DECIM, 3: decimation ratio; legal range 1..16.
- SHIFT, 6: arithmetic right-shift that removes coefficient scaling (Q6 coefficients); legal range 1..14.
- OUT_W, 8: output sample width, signed; legal range 4..16.
- DEPTH, 4: FIFO depth in entries; must be a power of 2, at least 2.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data is valid this cycle.
- in_data  in  16  signed FIR output y.
- out_valid  out  1  out_data holds a valid sample; equals FIFO not-empty.
- out_ready  in  1  consumer accepts the sample this cycle.
- out_data  out  OUT_W  signed decimated sample; FIFO head.
- sat_pulse  out  1  one-cycle pulse when the stage-1 result was clipped.
- overflow  out  1  sticky flag: a sample was dropped because the FIFO was full; cleared only by rst.

Behaviour:
- Reset, sampled on the rising edge with rst=1:
  - Phase counter = 0; stage-1 valid = 0.
  - FIFO empty, pointers = 0.
  - out_valid = 0, out_data = 0, sat_pulse = 0, overflow = 0.
- rst overrides all other inputs in the same cycle. Reset mid-operation discards buffered and in-flight samples.
- Phase counter:
  - Range 0..DECIM-1. Advances only on in_valid=1 and wraps DECIM-1 -> 0.
  - A sample is selected when in_valid=1 and phase==0. Other samples are discarded.
  - DECIM=1 selects every valid sample.
- Stage 1, registered:
  - Selected sample s computes r = (s + 2^(SHIFT-1)) >>> SHIFT, using a 17-bit intermediate so the add cannot wrap. Rounding is half-up.
  - r is clipped to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Result and s1_valid are registered at the same edge. sat_pulse is asserted for that one cycle if clipping occurred.
- FIFO write: when s1_valid=1, the registered value is pushed at the next edge.
  - If full and no pop occurs that cycle: push is dropped, FIFO contents are unchanged, overflow is set to 1.
  - If full and a pop occurs that same cycle: push succeeds and nothing is lost.
- FIFO read:
  - out_valid = !empty. out_data = head entry, combinational from the FIFO array.
  - Pop occurs when out_valid && out_ready.
  - out_ready while empty has no effect.
  - out_data holds its value while out_valid=1 && out_ready=0.
- Latency: in_valid on a selected sample at edge E0 -> stage 1 loaded at E0 -> FIFO written at E1 -> out_valid=1 in the cycle after E1. Total 2 edges when the FIFO is empty.
- Throughput: one output per DECIM valid inputs; sustains 1 sample per cycle with DECIM=1 and out_ready held high.
- Empty + simultaneous push: the FIFO becomes non-empty at that edge. There is no bypass path.
- Pointers are log2(DEPTH)+1 bits and wrap naturally. Full = MSBs differ and low bits equal.

Optional Feature:
- Macro FIR_OUT_DECIM_AVG_EN.
- When defined:
  - Each group of DECIM valid inputs is summed in an accumulator of 16+ceil(log2(DECIM)) bits.
  - At phase DECIM-1 the sum (including that sample) feeds stage 1 instead of the phase-0 sample. The accumulator is cleared at the same edge.
  - Rounding, shift and saturation apply to the sum unchanged. SHIFT must therefore absorb the DECIM gain.
  - rst clears the accumulator.
- When undefined: no accumulator; the phase-0 sample is kept and the rest are dropped.

Decomposition:
- Shared package fir_pkg holds:
  - FIR_DATA_W=16.
  - Function sat_round(value, shift, out_w) implementing the round/shift/clip rule above.
- One sub-module, fir_sync_fifo: parameterised width/depth, synchronous reset, push/pop/full/empty, with the combinational head read defined above.
- Phase counter, accumulator and stage 1 remain in fir_out_decim.

Test Plan:
- DECIM=1, out_ready=1, in_data=320 -> out_data=5, out_valid high exactly 2 edges after the input.
- Rounding, DECIM=1: in_data=32 -> 1; 31 -> 0; -32 -> 0; -33 -> -1; sat_pulse stays 0 for all four.
- Saturation: in_data=16000 -> 127 with sat_pulse=1 for one cycle; in_data=-16000 -> -128 with sat_pulse=1.
- DECIM=3, inputs 64,128,...,576 (nine valid, back-to-back) -> outputs 1,4,7.
  - With FIR_OUT_DECIM_AVG_EN and SHIFT=6: same inputs -> outputs 6,15,24.
- Backpressure, DEPTH=4, DECIM=1: out_ready=0, push 5 samples 1..5 -> overflow=1, FIFO holds 1..4. Then out_ready=1 -> reads 1,2,3,4 and out_valid drops.
- Reset mid-stream: 3 samples buffered, rst=1 for one cycle -> next cycle out_valid=0, overflow=0, phase=0. The next valid input is selected.
